// File: rtl/adder_accumulate_ctrl.sv
// Sequencer for an external ripple-carry adder. It holds the accumulator and the
// B register, waits a fixed settle time after each Run press, then captures Sum/CO.
module adder_accumulate_ctrl #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             LoadB,
    input  logic             ClearA,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Add_A,
    output logic [WIDTH-1:0] Add_B,
    input  logic [WIDTH-1:0] Add_Sum,
    input  logic             Add_CO,
    output logic [WIDTH-1:0] Acc,
    output logic [WIDTH-1:0] Breg,
    output logic             CO_flag,
    output logic             Done,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURE  = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // The counter runs 0..SETTLE_CYCLES-1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nxt_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] breg_r;
    logic             co_r;
    logic             done_r;
    logic             load_b_en_s;
    logic             clear_a_en_s;
    logic             capture_s;

    // State and settle-counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (Run) begin
                    state_nxt_s = SETTLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                cnt_nxt_s = cnt_r + 4'd1;
                if (cnt_r == SETTLE_LAST) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            CAPTURE: begin
                state_nxt_s = WAIT_REL;
            end
            WAIT_REL: begin
                if (Run) begin
                    state_nxt_s = WAIT_REL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Operand edits are honoured only while idle; a Run in the same cycle sees them.
    always_comb begin
        load_b_en_s  = 1'b0;
        clear_a_en_s = 1'b0;
        capture_s    = 1'b0;
        if (state_r == IDLE) begin
            load_b_en_s  = LoadB;
            clear_a_en_s = ClearA;
        end else if (state_r == CAPTURE) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Accumulator, B register, carry flag and completion pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_r  <= {WIDTH{1'b0}};
            breg_r <= {WIDTH{1'b0}};
            co_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (load_b_en_s) begin
                breg_r <= SW;
            end
            if (capture_s) begin
                acc_r <= Add_Sum;
                co_r  <= Add_CO;
            end else if (clear_a_en_s) begin
                acc_r <= {WIDTH{1'b0}};
                co_r  <= 1'b0;
            end
            done_r <= capture_s;
        end
    end

    assign Add_A   = acc_r;
    assign Add_B   = breg_r;
    assign Acc     = acc_r;
    assign Breg    = breg_r;
    assign CO_flag = co_r;
    assign Done    = done_r;
    assign Busy    = (state_r != IDLE);

endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
// Directed bench for adder_accumulate_ctrl with a behavioural adder alongside.
module tb_adder_accumulate_ctrl;

    localparam int WIDTH = 16;

    logic             Clk = 1'b0;
    logic             Reset, Run, LoadB, ClearA;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Add_A, Add_B, Add_Sum, Acc, Breg;
    logic             Add_CO, CO_flag, Done, Busy;

    int vectors = 0;
    int miscompares = 0;

    // The adder lives next to the controller, as in the real system.
    assign {Add_CO, Add_Sum} = {1'b0, Add_A} + {1'b0, Add_B};

    adder_accumulate_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .LoadB(LoadB), .ClearA(ClearA),
        .SW(SW), .Add_A(Add_A), .Add_B(Add_B), .Add_Sum(Add_Sum), .Add_CO(Add_CO),
        .Acc(Acc), .Breg(Breg), .CO_flag(CO_flag), .Done(Done), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        Reset = 1'b1; Run = 1'b0; LoadB = 1'b0; ClearA = 1'b0; SW = 16'h0000;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic load_b(input logic [WIDTH-1:0] v);
        SW = v; LoadB = 1'b1;
        @(negedge Clk);
        LoadB = 1'b0;
    endtask

    // One-cycle Run press, then enough cycles to return to IDLE.
    task automatic run_add();
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b1; LoadB = 1'b1; ClearA = 1'b1; SW = 16'hFFFF;
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b0; LoadB = 1'b0; ClearA = 1'b0;
        vectors++;
        if ({Acc, Breg, CO_flag, Done, Busy} !== {16'h0000, 16'h0000, 3'b000}) begin
            miscompares++;
            $display("FAIL reset: Acc=%h Breg=%h CO=%b Done=%b Busy=%b, want all zero",
                     Acc, Breg, CO_flag, Done, Busy);
        end
    endtask

    task automatic test_basic_add();
        do_reset();
        load_b(16'h1234);
        vectors++;
        if (Breg !== 16'h1234) begin
            miscompares++;
            $display("FAIL basic_loadb: Breg=%h want 1234", Breg);
        end
        Run = 1'b1;
        @(negedge Clk);                         // after t0
        Run = 1'b0;
        vectors++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_t0: Busy=%b Done=%b want 1 0", Busy, Done);
        end
        @(negedge Clk);                         // after t0+1
        @(negedge Clk);                         // after t0+2
        vectors++;
        if (Acc !== 16'h0000 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early: Acc=%h Done=%b want 0000 0", Acc, Done);
        end
        @(negedge Clk);                         // after t0+3
        vectors++;
        if (Acc !== 16'h1234 || CO_flag !== 1'b0 || Done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_capture: Acc=%h CO=%b Done=%b want 1234 0 1", Acc, CO_flag, Done);
        end
        @(negedge Clk);                         // after t0+4
        vectors++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_end: Done=%b Busy=%b want 0 0", Done, Busy);
        end
    endtask

    task automatic test_carry_wrap();
        do_reset();
        load_b(16'hFFFF);
        run_add();
        vectors++;
        if (Acc !== 16'hFFFF || CO_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_setup: Acc=%h CO=%b want ffff 0", Acc, CO_flag);
        end
        load_b(16'h0001);
        run_add();
        vectors++;
        if (Acc !== 16'h0000 || CO_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_wrap: Acc=%h CO=%b want 0000 1", Acc, CO_flag);
        end
        load_b(16'h0005);
        run_add();
        vectors++;
        if (Acc !== 16'h0005 || CO_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_notsticky: Acc=%h CO=%b want 0005 0", Acc, CO_flag);
        end
        ClearA = 1'b1;
        @(negedge Clk);
        ClearA = 1'b0;
        vectors++;
        if (Acc !== 16'h0000 || CO_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_idle: Acc=%h CO=%b want 0000 0", Acc, CO_flag);
        end
    endtask

    task automatic test_hold_run();
        int dones = 0;
        int busy_bad = 0;
        do_reset();
        load_b(16'h0003);
        Run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) dones++;
            if (Busy !== 1'b1) busy_bad++;
        end
        Run = 1'b0;
        vectors++;
        if (busy_bad != 0) begin
            miscompares++;
            $display("FAIL hold_busy: Busy low in %0d cycles, want 0", busy_bad);
        end
        vectors++;
        if (dones != 1 || Acc !== 16'h0003) begin
            miscompares++;
            $display("FAIL hold_once: dones=%0d Acc=%h want 1 0003", dones, Acc);
        end
        @(negedge Clk);
        vectors++;
        if (Busy !== 1'b0 || Acc !== 16'h0003) begin
            miscompares++;
            $display("FAIL hold_release: Busy=%b Acc=%h want 0 0003", Busy, Acc);
        end
    endtask

    task automatic test_ignore_in_settle();
        do_reset();
        load_b(16'h0007);
        run_add();                              // Acc = 0007
        Run = 1'b1;
        @(negedge Clk);                         // after t0: in SETTLE
        Run = 1'b0; SW = 16'hAAAA; LoadB = 1'b1; ClearA = 1'b1;
        @(negedge Clk);                         // after t0+1
        vectors++;
        if (Breg !== 16'h0007 || Acc !== 16'h0007) begin
            miscompares++;
            $display("FAIL settle_ignore: Breg=%h Acc=%h want 0007 0007", Breg, Acc);
        end
        @(negedge Clk);                         // after t0+2
        @(negedge Clk);                         // after t0+3: captured
        vectors++;
        if (Acc !== 16'h000E || Done !== 1'b1 || Breg !== 16'h0007) begin
            miscompares++;
            $display("FAIL settle_capture: Acc=%h Done=%b Breg=%h want 000e 1 0007", Acc, Done, Breg);
        end
        LoadB = 1'b0; ClearA = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset_mid_op();
        int late_done = 0;
        Run = 1'b1;
        @(negedge Clk);                         // after t0: SETTLE cycle 1
        Run = 1'b0; Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        vectors++;
        if ({Acc, Breg, CO_flag, Done, Busy} !== {16'h0000, 16'h0000, 3'b000}) begin
            miscompares++;
            $display("FAIL midreset: Acc=%h Breg=%h CO=%b Done=%b Busy=%b, want all zero",
                     Acc, Breg, CO_flag, Done, Busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (Done === 1'b1 || Busy === 1'b1) late_done++;
        end
        vectors++;
        if (late_done != 0 || Acc !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_nocapture: activity=%0d Acc=%h want 0 0000", late_done, Acc);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        load_b(16'h0100);
        run_add();                              // Acc = 0100
        vectors++;
        if (Acc !== 16'h0100) begin
            miscompares++;
            $display("FAIL simul_setup: Acc=%h want 0100", Acc);
        end
        SW = 16'h0010; LoadB = 1'b1; ClearA = 1'b1; Run = 1'b1;
        @(negedge Clk);
        LoadB = 1'b0; ClearA = 1'b0; Run = 1'b0;
        vectors++;
        if (Breg !== 16'h0010 || Acc !== 16'h0000 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_t0: Breg=%h Acc=%h Busy=%b want 0010 0000 1", Breg, Acc, Busy);
        end
        repeat (3) @(negedge Clk);
        vectors++;
        if (Acc !== 16'h0010 || CO_flag !== 1'b0 || Done !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_result: Acc=%h CO=%b Done=%b want 0010 0 1", Acc, CO_flag, Done);
        end
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; LoadB = 1'b0; ClearA = 1'b0; SW = 16'h0000;
        @(negedge Clk);
        test_reset();
        test_basic_add();
        test_carry_wrap();
        test_hold_run();
        test_ignore_in_settle();
        test_reset_mid_op();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
